axis_video_pattern_source: RTL and testbench

//  AXI4-Stream video master that generates complete test frames (colour bars, checkerboard,

---
 rtl/axis_video_pattern_source.sv | 168 ++++++++++++++++
 tb/tb_axis_video_pattern_source.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_pattern_source.sv
// AXI4-Stream test-frame generator: bars, checker, ramp, solid; no frame memory.
// Ports: clk, rst_n, enable, pattern_sel -> m_axis_{tdata,tvalid,tuser,tlast}, m_axis_tready in, frame_count, frame_done.
module axis_video_pattern_source #(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 1024,
  parameter int COL_ADDR_WIDTH = 11,
  parameter int ROW_ADDR_WIDTH = 10,
  parameter int BAR_WIDTH      = 160,
  parameter int CHECK_SHIFT    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] frame_count,
  output logic        frame_done
);

  localparam int CW  = COL_ADDR_WIDTH;
  localparam int RW  = ROW_ADDR_WIDTH;
  localparam int BPW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [CW-1:0]  COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [BPW-1:0] BPX_LAST = BPW'(BAR_WIDTH - 1);

  logic [0:0]     state;
  logic [CW-1:0]  col, n_col;
  logic [RW-1:0]  row, n_row;
  logic [BPW-1:0] bpx, n_bpx;
  logic [2:0]     bidx, n_bidx;
  logic [1:0]     pat, n_pat;
  logic [15:0]    n_fc;
  logic [23:0]    n_pix;
  logic           n_user, n_last;
  logic           xfer, col_end, frame_end, adv;

  function automatic logic [23:0] bar_rgb(input logic [2:0] b);
    logic [23:0] v;
    case (b)
      3'd0:    v = 24'hFFFFFF;
      3'd1:    v = 24'hFFFF00;
      3'd2:    v = 24'h00FFFF;
      3'd3:    v = 24'h00FF00;
      3'd4:    v = 24'hFF00FF;
      3'd5:    v = 24'hFF0000;
      3'd6:    v = 24'h0000FF;
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

  function automatic logic [23:0] pixel(
    input logic [CW-1:0] c,
    input logic [RW-1:0] r,
    input logic [2:0]    b,
    input logic [1:0]    p,
    input logic [7:0]    f
  );
    logic [23:0] v;
    logic        ck;
    logic [7:0]  rm;
    ck = |((c >> CHECK_SHIFT) & CW'(1))
       ^ |((r >> CHECK_SHIFT) & RW'(1));
    rm = 8'(c);
    unique case (p)
      2'd0:    v = bar_rgb(b);
      2'd1:    v = ck ? 24'hFFFFFF : 24'h000000;
      2'd2:    v = {rm, rm, rm};
      default: v = {f, 8'h00, ~f};
    endcase
    return v;
  endfunction

  assign xfer      = m_axis_tvalid & m_axis_tready;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end & (row == ROW_LAST);

  // Coordinates of the pixel to present next. Leaving IDLE or crossing a
  // frame boundary restarts at (0,0) with a freshly latched pattern.
  always_comb begin
    n_col  = '0;
    n_row  = '0;
    n_bpx  = '0;
    n_bidx = '0;
    n_pat  = pattern_sel;
    n_fc   = frame_count;
    if (state == S_STREAM) begin
      if (frame_end) begin
        n_fc = frame_count + 16'd1;
      end else begin
        n_pat = pat;
        if (col_end) begin
          n_row = row + RW'(1);
        end else begin
          n_row = row;
          n_col = col + CW'(1);
          if (bpx == BPX_LAST) begin
            n_bidx = bidx + 3'd1;
          end else begin
            n_bpx  = bpx + BPW'(1);
            n_bidx = bidx;
          end
        end
      end
    end
  end

  assign n_pix  = pixel(n_col, n_row, n_bidx, n_pat, n_fc[7:0]);
  assign n_user = (n_col == '0) && (n_row == '0);
  assign n_last = (n_col == COL_LAST);

  assign adv = (state == S_IDLE) ? enable
             : (xfer & ~(frame_end & ~enable));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      col           <= '0;
      row           <= '0;
      bpx           <= '0;
      bidx          <= '0;
      pat           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_count   <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_STREAM && xfer && frame_end) begin
        frame_count <= n_fc;
        frame_done  <= 1'b1;
      end
      if (adv) begin
        state         <= S_STREAM;
        col           <= n_col;
        row           <= n_row;
        bpx           <= n_bpx;
        bidx          <= n_bidx;
        pat           <= n_pat;
        m_axis_tdata  <= n_pix;
        m_axis_tuser  <= n_user;
        m_axis_tlast  <= n_last;
        m_axis_tvalid <= 1'b1;
      end else if (state == S_STREAM && xfer) begin
        state         <= S_IDLE;
        col           <= '0;
        row           <= '0;
        bpx           <= '0;
        bidx          <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_source.sv
// Directed bench for axis_video_pattern_source at 8x4, bars of 2, checker of 2.
// Covers reset, all patterns, backpressure, frame boundaries, mid-frame reset.
module tb_axis_video_pattern_source;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [15:0] fc;
  logic        fd;

  int checks   = 0;
  int failures = 0;
  logic rdy_rand;
  logic [23:0] first;
  logic [23:0] d;
  logic        u;
  logic        l;

  axis_video_pattern_source #(
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .COL_ADDR_WIDTH(3),
    .ROW_ADDR_WIDTH(2),
    .BAR_WIDTH(2),
    .CHECK_SHIFT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tuser(tuser),
    .m_axis_tlast(tlast),
    .frame_count(fc),
    .frame_done(fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(input int sel, input int c,
                                         input int r, input int f);
    logic [23:0] v;
    logic [7:0]  c8;
    logic [7:0]  f8;
    c8 = 8'(c);
    f8 = 8'(f);
    case (sel)
      0: case (c / 2)
           0: v = 24'hFFFFFF;
           1: v = 24'hFFFF00;
           2: v = 24'h00FFFF;
           default: v = 24'h00FF00;
         endcase
      1: v = ((((c >> 1) ^ (r >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2: v = {c8, c8, c8};
      default: v = {f8, 8'h00, ~f8};
    endcase
    return v;
  endfunction

  task automatic get_px(output logic [23:0] od, output logic ou,
                        output logic ol);
    logic        held = 1'b0;
    logic [26:0] hv = '0;
    od = '0;
    ou = 1'b0;
    ol = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held)
        chk("stable", {5'b0, tvalid, tuser, tlast, tdata}, {5'b0, hv});
      if (tvalid && tready) begin
        od = tdata;
        ou = tuser;
        ol = tlast;
        return;
      end
      held = tvalid;
      hv   = {tvalid, tuser, tlast, tdata};
    end
    chk("timeout", 0, 1);
  endtask

  task automatic run_frame(input int sel, input int f, input int npx,
                           input int act_at, input logic act_en,
                           input logic [1:0] act_sel,
                           output logic [23:0] fp);
    logic [23:0] pd;
    logic        pu;
    logic        pl;
    fp = '0;
    for (int i = 0; i < npx; i++) begin
      if (i == act_at) begin
        enable      = act_en;
        pattern_sel = act_sel;
      end
      get_px(pd, pu, pl);
      if (i == 0) fp = pd;
      chk("tdata", {8'h0, pd}, {8'h0, exp_px(sel, i % 8, i / 8, f)});
      chk("tuser", {31'h0, pu}, {31'h0, (i == 0)});
      chk("tlast", {31'h0, pl}, {31'h0, ((i % 8) == 7)});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    tready      = 1'b0;
    rdy_rand    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'h0, tvalid}, 0);
    chk("rst_tdata", {8'h0, tdata}, 0);
    chk("rst_tuser", {31'h0, tuser}, 0);
    chk("rst_tlast", {31'h0, tlast}, 0);
    chk("rst_fc", {16'h0, fc}, 0);
    chk("rst_fd", {31'h0, fd}, 0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_tvalid", {31'h0, tvalid}, 0);
      chk("idle_fc", {16'h0, fc}, 0);
      chk("idle_fd", {31'h0, fd}, 0);
    end

    // bars, full rate; sel change mid-frame takes effect next frame
    enable      = 1'b1;
    pattern_sel = 2'd0;
    run_frame(0, 0, 32, 16, 1'b1, 2'd1, first);
    chk("bars_first", {8'h0, first}, 32'h00FFFFFF);
    @(negedge clk);
    chk("fd_pulse", {31'h0, fd}, 1);
    chk("fc_1", {16'h0, fc}, 1);
    chk("b2b_tvalid", {31'h0, tvalid}, 1);
    chk("b2b_tuser", {31'h0, tuser}, 1);
    chk("b2b_tdata", {8'h0, tdata}, 32'h0);
    tready = 1'b0;
    @(negedge clk);
    chk("fd_width", {31'h0, fd}, 0);

    // checker under backpressure; enable drops and sel changes mid-frame
    rdy_rand = 1'b1;
    run_frame(1, 1, 32, 10, 1'b0, 2'd2, first);
    @(negedge clk);
    tready = 1'b0;
    chk("stop_tvalid", {31'h0, tvalid}, 0);
    chk("stop_fd", {31'h0, fd}, 1);
    chk("fc_2", {16'h0, fc}, 2);
    repeat (3) begin
      @(negedge clk);
      chk("idle2_tvalid", {31'h0, tvalid}, 0);
    end

    // ramp
    enable = 1'b1;
    run_frame(2, 2, 32, 5, 1'b0, 2'd2, first);
    @(negedge clk);
    tready = 1'b0;
    chk("ramp_stop", {31'h0, tvalid}, 0);
    chk("fc_3", {16'h0, fc}, 3);

    // solid over three frames from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_fc", {16'h0, fc}, 0);
    rst_n       = 1'b1;
    rdy_rand    = 1'b0;
    pattern_sel = 2'd3;
    enable      = 1'b1;
    run_frame(3, 0, 32, -1, 1'b1, 2'd3, first);
    chk("solid0", {8'h0, first}, 32'h000000FF);
    run_frame(3, 1, 32, -1, 1'b1, 2'd3, first);
    chk("solid1", {8'h0, first}, 32'h000100FE);
    run_frame(3, 2, 32, 20, 1'b0, 2'd3, first);
    chk("solid2", {8'h0, first}, 32'h000200FD);
    @(negedge clk);
    tready = 1'b0;
    chk("solid_stop", {31'h0, tvalid}, 0);
    chk("fc_3b", {16'h0, fc}, 3);

    // reset at row 2, col 5 while valid
    pattern_sel = 2'd0;
    enable      = 1'b1;
    run_frame(0, 3, 21, -1, 1'b1, 2'd0, first);
    @(negedge clk);
    tready = 1'b0;
    chk("mid_tvalid", {31'h0, tvalid}, 1);
    chk("mid_tdata", {8'h0, tdata}, 32'h0000FFFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_tvalid", {31'h0, tvalid}, 0);
    chk("mrst_fc", {16'h0, fc}, 0);
    chk("mrst_fd", {31'h0, fd}, 0);
    rst_n = 1'b1;
    get_px(d, u, l);
    chk("resume_tuser", {31'h0, u}, 1);
    chk("resume_tdata", {8'h0, d}, 32'h00FFFFFF);
    chk("resume_tlast", {31'h0, l}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
